// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if
// Write-side bundle between the producer, the FIFO write-pointer/full logic
// and the write port of the dual-port memory.
//
//   wr_en        producer write request
//   rptr_sync    Gray read pointer, already synchronized into the write clock
//   wr_accept    memory write enable (wr_en qualified by ~full)
//   waddr        memory write address
//   wptr         registered Gray write pointer for the read-side synchronizer
//   full         registered full flag
//   almost_full  registered almost-full flag
//   wr_level     registered occupancy estimate, 0..2**ADDR_WIDTH
//
// Optional, when FIFO_WR_OVERFLOW_FLAG_EN is defined:
//   ovf_clr      clears the sticky overflow flag
//   overflow     sticky flag, set by a write request while full
//
// Modports: master = producer / environment side, slave = fifo_wptr_full.

interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rptr_sync;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  logic                  ovf_clr;
  logic                  overflow;
`endif

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  modport master (
    output wr_en,
    output rptr_sync,
    output ovf_clr,
    input  wr_accept,
    input  waddr,
    input  wptr,
    input  full,
    input  almost_full,
    input  wr_level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  rptr_sync,
    input  ovf_clr,
    output wr_accept,
    output waddr,
    output wptr,
    output full,
    output almost_full,
    output wr_level,
    output overflow
  );
`else
  modport master (
    output wr_en,
    output rptr_sync,
    input  wr_accept,
    input  waddr,
    input  wptr,
    input  full,
    input  almost_full,
    input  wr_level
  );

  modport slave (
    input  wr_en,
    input  rptr_sync,
    output wr_accept,
    output waddr,
    output wptr,
    output full,
    output almost_full,
    output wr_level
  );
`endif

endinterface

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Keeps a binary write pointer that advances on accepted writes, drives the
// memory write address/enable, publishes the registered Gray write pointer
// for the read-side synchronizer, and compares against the synchronized read
// pointer to produce full, almost_full and a fill-level estimate.
//
// Ports:
//   clk    write-domain clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_wptr_full_if.slave (wr_en, rptr_sync in; wr_accept, waddr,
//          wptr, full, almost_full, wr_level out)
//
// Parameters:
//   ADDR_WIDTH          memory address width, depth = 2**ADDR_WIDTH
//   ALMOST_FULL_THRESH  almost_full when free entries <= this (1..depth-1)
//
// Optional feature: define FIFO_WR_OVERFLOW_FLAG_EN to add bus.ovf_clr and
// the sticky bus.overflow flag.

module fifo_wptr_full #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 2
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wptr_full_if.slave   bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the two MSBs differ and the rest match.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  // Occupancy at and above which almost_full is raised.
  localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - ALMOST_FULL_THRESH);

  logic [PW-1:0] wbin_q,        wbin_d;
  logic [PW-1:0] wptr_q,        wptr_d;
  logic          full_q,        full_d;
  logic          almost_full_q, almost_full_d;
  logic [PW-1:0] wr_level_q,    wr_level_d;

  logic          wr_accept;
  logic [PW-1:0] rbin_s;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(bus.rptr_sync >> i);
    end
  end

  // Pointer advance, new read pointer and flag computation are all folded
  // into one next-state evaluation, so a write and a read-pointer update in
  // the same cycle need no priority.
  always_comb begin
    wr_accept     = bus.wr_en & ~full_q;
    wbin_d        = wbin_q + PW'(wr_accept);
    wptr_d        = wbin_d ^ (wbin_d >> 1);
    full_d        = (wptr_d == (bus.rptr_sync ^ FULL_MASK));
    wr_level_d    = wbin_d - rbin_s;
    almost_full_d = (wr_level_d >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_level_q    <= wr_level_d;
    end
  end

  assign bus.wr_accept   = wr_accept;
  assign bus.waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wr_level    = wr_level_q;

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // Sticky; a new overflow in the clearing cycle must not be lost, so set
  // takes precedence over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  localparam int AW     = 4;
  localparam int PW     = AW + 1;
  localparam int DEPTH  = 1 << AW;
  localparam int THRESH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH         (AW),
    .ALMOST_FULL_THRESH (THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          wr_accept;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;
    logic          overflow;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: binary write count, registered flags as they should
  // appear after the most recent clock edge.
  logic [PW-1:0] m_wbin = '0;
  logic [PW-1:0] m_wptr = '0;
  logic [PW-1:0] m_lvl  = '0;
  logic          m_full = 1'b0;
  logic          m_af   = 1'b0;
  logic          m_ovf  = 1'b0;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus. Inputs change 1 time unit after the rising edge;
  // the expectation pushed describes what the DUT shows until the next edge.
  task automatic step(input logic we, input logic [PW-1:0] rbin,
                      input logic clr, input logic rst);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.wr_en     = we;
    bus.rptr_sync = to_gray(rbin);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    bus.ovf_clr   = clr;
`endif
    if (!rst) begin
      m_wbin = '0; m_wptr = '0; m_lvl = '0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end
    e.wr_accept   = we & ~m_full;
    e.waddr       = m_wbin[AW-1:0];
    e.wptr        = m_wptr;
    e.full        = m_full;
    e.almost_full = m_af;
    e.wr_level    = m_lvl;
    e.overflow    = m_ovf;
    exp_q.push_back(e);
    if (rst) begin
      acc = we & ~m_full;
      if (we && m_full) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      m_wbin = m_wbin + PW'(acc);
      m_wptr = to_gray(m_wbin);
      m_lvl  = m_wbin - rbin;
      m_full = (int'(m_lvl) == DEPTH);
      m_af   = (DEPTH - int'(m_lvl)) <= THRESH;
    end
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_accept",   32'(bus.wr_accept),   32'(e.wr_accept));
        chk("waddr",       32'(bus.waddr),       32'(e.waddr));
        chk("wptr",        32'(bus.wptr),        32'(e.wptr));
        chk("full",        32'(bus.full),        32'(e.full));
        chk("almost_full", 32'(bus.almost_full), 32'(e.almost_full));
        chk("wr_level",    32'(bus.wr_level),    32'(e.wr_level));
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
        chk("overflow",    32'(bus.overflow),    32'(e.overflow));
`endif
      end
    end
  end

  initial begin
    bus.wr_en     = 1'b0;
    bus.rptr_sync = '0;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    bus.ovf_clr   = 1'b0;
`endif

    // Reset held, then released.
    repeat (3) step(1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b1);

    // Fill from empty, then keep requesting while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'd0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 5'd0, 1'b0, 1'b1);

    // One read arrives: full drops, one more write lands at waddr 0.
    step(1'b0, 5'd1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b0, 1'b1);

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
    // Clear coinciding with another overflow, then a plain clear.
    step(1'b1, 5'd1, 1'b1, 1'b1);
    step(1'b0, 5'd1, 1'b1, 1'b1);
    step(1'b0, 5'd1, 1'b0, 1'b1);
`endif

    // Drain completely.
    step(1'b0, 5'd17, 1'b0, 1'b1);
    step(1'b0, 5'd17, 1'b0, 1'b1);

    // Two writes ahead, then 40 writes with the reader trailing (wraps).
    step(1'b1, 5'd17, 1'b0, 1'b1);
    step(1'b1, 5'd17, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, PW'(m_wbin - 5'd1), 1'b0, 1'b1);

    // Reset asserted between clock edges in the middle of a burst.
    step(1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 5'd0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 5'd0, 1'b0, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
